// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the HMS time-of-day sequencer.
//   state_e       : CLOCK / SET_SEC / SET_MIN / SET_HR mode state
//   rep_phase_e   : auto-repeat phase of the increment button
//   POS_*, MODE_* : encodings driven on o_position / o_mode
//   BLANK_*       : digit-pair masks for o_blank
//   pos_of_state, blank_of_state : decode helpers from state
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      StClock  = 2'd0,
      StSetSec = 2'd1,
      StSetMin = 2'd2,
      StSetHr  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      RpIdle   = 2'd0,
      RpHold   = 2'd1,
      RpRepeat = 2'd2
   } rep_phase_e;

   localparam logic [1:0] POS_SEC    = 2'b00;
   localparam logic [1:0] POS_MIN    = 2'b01;
   localparam logic [1:0] POS_HR     = 2'b10;

   localparam logic       MODE_CLOCK = 1'b0;
   localparam logic       MODE_SETUP = 1'b1;

   localparam logic [5:0] BLANK_NONE = 6'b000000;
   localparam logic [5:0] BLANK_SEC  = 6'b000011;
   localparam logic [5:0] BLANK_MIN  = 6'b001100;
   localparam logic [5:0] BLANK_HR   = 6'b110000;

   // CLOCK reports the SEC position so o_position never shows 11.
   function automatic logic [1:0] pos_of_state(state_e s);
      logic [1:0] pos;
      unique case (s)
         StClock:  pos = POS_SEC;
         StSetSec: pos = POS_SEC;
         StSetMin: pos = POS_MIN;
         StSetHr:  pos = POS_HR;
      endcase
      return pos;
   endfunction

   function automatic logic [5:0] blank_of_state(state_e s);
      logic [5:0] mask;
      unique case (s)
         StClock:  mask = BLANK_NONE;
         StSetSec: mask = BLANK_SEC;
         StSetMin: mask = BLANK_MIN;
         StSetHr:  mask = BLANK_HR;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// Auto-repeat generator for the increment button.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   i_press    : one-cycle press edge of the button
//   i_held     : debounced button level
//   i_tick     : repeat timebase pulse (100 Hz)
//   i_clear    : abort any repeat in progress (mode/field change)
//   o_fire     : combinational one-cycle fire request, registered by the parent
module key_repeat
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned HOLD_TICKS   = 50,
   parameter int unsigned REPEAT_TICKS = 10,
   parameter int unsigned CNT_W        = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_press,
   input  logic i_held,
   input  logic i_tick,
   input  logic i_clear,
   output logic o_fire
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [CNT_W-1:0] w_limit;
   rep_phase_e       r_phase;
   rep_phase_e       w_phase_next;
   logic             w_fire;

   always_comb begin
      w_fire       = 1'b0;
      w_cnt_next   = r_cnt;
      w_phase_next = r_phase;
      w_cnt_inc    = r_cnt + CNT_W'(1);
      w_limit      = (r_phase == RpHold) ? CNT_W'(HOLD_TICKS) : CNT_W'(REPEAT_TICKS);

      if (i_clear) begin
         w_cnt_next   = '0;
         w_phase_next = RpIdle;
      end else if (i_press) begin
         w_fire       = 1'b1;
         w_cnt_next   = '0;
         w_phase_next = RpHold;
      end else if (!i_held) begin
         w_cnt_next   = '0;
         w_phase_next = RpIdle;
      end else if ((r_phase != RpIdle) && i_tick) begin
         // A held button that was never pressed in this field stays idle.
         if (w_cnt_inc == w_limit) begin
            w_fire       = 1'b1;
            w_cnt_next   = '0;
            w_phase_next = RpRepeat;
         end else begin
            w_cnt_next = w_cnt_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_phase <= RpIdle;
      end else begin
         r_cnt   <= w_cnt_next;
         r_phase <= w_phase_next;
      end
   end

   assign o_fire = w_fire;

endmodule

// File: rtl/clock_setup_ctrl.sv
// CLOCK/SETUP sequencer for the HMS time-of-day datapath. Produces one-cycle
// increment enables for the sec/min/hr counters, runs the mode/field FSM,
// auto-repeats the set button and drives the per-digit blink mask.
// Ports:
//   clk, rst_n          : 50 MHz clock, synchronous active-low reset
//   i_tick_1hz          : 1 Hz timebase pulse
//   i_tick_100hz        : 100 Hz pulse for auto-repeat timing
//   i_tick_blink        : 4 Hz pulse toggling blink phase
//   i_sw0/i_sw1/i_sw2   : mode / position / increment button levels
//   i_sec_at_max        : sec counter == 59
//   i_min_at_max        : min counter == 59
//   o_mode              : 0 = CLOCK, 1 = SETUP
//   o_position          : 00 SEC, 01 MIN, 10 HR
//   o_sec/min/hr_inc    : registered one-cycle increment enables
//   o_blank             : digit blank mask, 1 = blank
module clock_setup_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned HOLD_TICKS   = 50,
   parameter int unsigned REPEAT_TICKS = 10,
   parameter int unsigned CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_tick_1hz,
   input  logic       i_tick_100hz,
   input  logic       i_tick_blink,
   input  logic       i_sw0,
   input  logic       i_sw1,
   input  logic       i_sw2,
   input  logic       i_sec_at_max,
   input  logic       i_min_at_max,
   output logic       o_mode,
   output logic [1:0] o_position,
   output logic       o_sec_inc,
   output logic       o_min_inc,
   output logic       o_hr_inc,
   output logic [5:0] o_blank
);

   state_e     r_state;
   state_e     w_state_next;

   logic       r_prev_sw0;
   logic       r_prev_sw1;
   logic       r_prev_sw2;
   logic       w_press_sw0;
   logic       w_press_sw1;
   logic       w_press_sw2;

   logic       w_setup;
   logic       w_rep_clear;
   logic       w_fire;

   logic       r_sec_inc;
   logic       r_min_inc;
   logic       r_hr_inc;
   logic       w_sec_inc_next;
   logic       w_min_inc_next;
   logic       w_hr_inc_next;

   logic       r_blink;
   logic       w_blink_next;
   logic [5:0] r_blank;
   logic [5:0] w_blank_next;

   assign w_press_sw0 = i_sw0 & ~r_prev_sw0;
   assign w_press_sw1 = i_sw1 & ~r_prev_sw1;
   assign w_press_sw2 = i_sw2 & ~r_prev_sw2;

   assign w_setup     = (r_state != StClock);

   // Any mode or field change aborts the repeat and swallows a coincident sw2 press.
   assign w_rep_clear = ~w_setup | w_press_sw0 | w_press_sw1;

   key_repeat #(
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .CNT_W        (CNT_W)
   ) u_key_repeat (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_press (w_press_sw2),
      .i_held  (i_sw2),
      .i_tick  (i_tick_100hz),
      .i_clear (w_rep_clear),
      .o_fire  (w_fire)
   );

   // Mode/field FSM; sw0 takes priority over sw1.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StClock: begin
            if (w_press_sw0) w_state_next = StSetSec;
         end
         StSetSec: begin
            if (w_press_sw0)      w_state_next = StClock;
            else if (w_press_sw1) w_state_next = StSetMin;
         end
         StSetMin: begin
            if (w_press_sw0)      w_state_next = StClock;
            else if (w_press_sw1) w_state_next = StSetHr;
         end
         StSetHr: begin
            if (w_press_sw0)      w_state_next = StClock;
            else if (w_press_sw1) w_state_next = StSetSec;
         end
      endcase
   end

   // Increment enables; CLOCK follows the 1 Hz carry chain, SETUP only the
   // selected field from the repeat engine. The current state decides, so a
   // tick coinciding with the CLOCK->SETUP press is still honoured.
   always_comb begin
      w_sec_inc_next = 1'b0;
      w_min_inc_next = 1'b0;
      w_hr_inc_next  = 1'b0;
      unique case (r_state)
         StClock: begin
            w_sec_inc_next = i_tick_1hz;
            w_min_inc_next = i_tick_1hz & i_sec_at_max;
            w_hr_inc_next  = i_tick_1hz & i_sec_at_max & i_min_at_max;
         end
         StSetSec: w_sec_inc_next = w_fire;
         StSetMin: w_min_inc_next = w_fire;
         StSetHr:  w_hr_inc_next  = w_fire;
      endcase
   end

   // Holding sw2 keeps the field visible while it is being adjusted.
   always_comb begin
      w_blink_next = w_setup ? (r_blink ^ i_tick_blink) : 1'b0;
      w_blank_next = BLANK_NONE;
      if (w_setup && r_blink && !i_sw2) begin
         w_blank_next = blank_of_state(r_state);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= StClock;
         // History starts high so a button held through reset is not a press.
         r_prev_sw0 <= 1'b1;
         r_prev_sw1 <= 1'b1;
         r_prev_sw2 <= 1'b1;
         r_sec_inc  <= 1'b0;
         r_min_inc  <= 1'b0;
         r_hr_inc   <= 1'b0;
         r_blink    <= 1'b0;
         r_blank    <= BLANK_NONE;
      end else begin
         r_state    <= w_state_next;
         r_prev_sw0 <= i_sw0;
         r_prev_sw1 <= i_sw1;
         r_prev_sw2 <= i_sw2;
         r_sec_inc  <= w_sec_inc_next;
         r_min_inc  <= w_min_inc_next;
         r_hr_inc   <= w_hr_inc_next;
         r_blink    <= w_blink_next;
         r_blank    <= w_blank_next;
      end
   end

   assign o_mode     = w_setup ? MODE_SETUP : MODE_CLOCK;
   assign o_position = pos_of_state(r_state);
   assign o_sec_inc  = r_sec_inc;
   assign o_min_inc  = r_min_inc;
   assign o_hr_inc   = r_hr_inc;
   assign o_blank    = r_blank;

endmodule
